// File: rtl/crnn_fixed_pkg.sv
// rtl/crnn_fixed_pkg.sv - shared Q-format constants, saturation limits and stream state for CRNN stages
package crnn_fixed_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRACT_WIDTH = 8;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

endpackage

// File: rtl/fixed_add_sat.sv
// rtl/fixed_add_sat.sv - combinational sign-extended add with saturation to DATA_WIDTH bits
module fixed_add_sat #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] sum
);

  localparam logic signed [DATA_WIDTH-1:0] LIM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] LIM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH:0] wide;

  assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
      sum = wide[DATA_WIDTH] ? LIM_MIN : LIM_MAX;
    end else begin
      sum = wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/matmul_bias_relu_streamer.sv
// rtl/matmul_bias_relu_streamer.sv - captures an MxP result plus bias, adds with saturation, streams row-major; MATMUL_RELU_EN enables ReLU
module matmul_bias_relu_streamer
  import crnn_fixed_pkg::*;
#(
  parameter  int M           = 4,
  parameter  int P           = 5,
  parameter  int DATA_WIDTH  = crnn_fixed_pkg::DATA_WIDTH,
  parameter  int FRACT_WIDTH = crnn_fixed_pkg::FRACT_WIDTH,
  localparam int ROW_W       = (M > 1) ? $clog2(M) : 1,
  localparam int COL_W       = (P > 1) ? $clog2(P) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [M*P*DATA_WIDTH-1:0]    in_y,
  input  logic [P*DATA_WIDTH-1:0]      in_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ROW_W-1:0]             out_row,
  output logic [COL_W-1:0]             out_col,
  output logic                         out_last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M-1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(P-1);

  stream_state_t                 state;
  logic [M*P*DATA_WIDTH-1:0]     y_q;
  logic [P*DATA_WIDTH-1:0]       bias_q;
  logic [ROW_W-1:0]              row_q;
  logic [COL_W-1:0]              col_q;

  logic                          is_last;
  logic signed [DATA_WIDTH-1:0]  y_elem;
  logic signed [DATA_WIDTH-1:0]  bias_elem;
  logic signed [DATA_WIDTH-1:0]  sat_sum;
  logic signed [DATA_WIDTH-1:0]  proc_data;

  assign is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    y_elem    = y_q[(int'(row_q) * P + int'(col_q)) * DATA_WIDTH +: DATA_WIDTH];
    bias_elem = bias_q[int'(col_q) * DATA_WIDTH +: DATA_WIDTH];
  end

  fixed_add_sat #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_add_sat (
    .a   (y_elem),
    .b   (bias_elem),
    .sum (sat_sum)
  );

`ifdef MATMUL_RELU_EN
  assign proc_data = sat_sum[DATA_WIDTH-1] ? '0 : sat_sum;
`else
  assign proc_data = sat_sum;
`endif

  // Handshake flags decode the state register only, so in_ready never sees in_valid.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign out_data  = out_valid ? proc_data : '0;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_valid && is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      y_q    <= '0;
      bias_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_q    <= in_y;
            bias_q <= in_bias;
            row_q  <= '0;
            col_q  <= '0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (is_last) begin
              row_q <= '0;
              col_q <= '0;
              state <= IDLE;
            end else if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_bias_relu_streamer.sv
// tb/tb_matmul_bias_relu_streamer.sv - scoreboard bench for matmul_bias_relu_streamer
module tb_matmul_bias_relu_streamer;

  localparam int M  = 4;
  localparam int P  = 5;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [M*P*DW-1:0]    in_y;
  logic [P*DW-1:0]      in_bias;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_row;
  logic [2:0]           out_col;
  logic                 out_last;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            r;
    int            c;
    bit            last;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  matmul_bias_relu_streamer #(.M(M), .P(P), .DATA_WIDTH(DW), .FRACT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  function automatic logic [DW-1:0] model(input logic signed [DW-1:0] y, input logic signed [DW-1:0] b);
    int s;
    s = int'(y) + int'(b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef MATMUL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[DW-1:0];
  endfunction

  task automatic push_expected(input logic [M*P*DW-1:0] y, input logic [P*DW-1:0] b);
    exp_t e;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        e.d    = model(y[(r*P+c)*DW +: DW], b[c*DW +: DW]);
        e.r    = r;
        e.c    = c;
        e.last = (r == M-1) && (c == P-1);
        sb.push_back(e);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where the first element is visible.
  task automatic load_matrix(input logic [M*P*DW-1:0] y, input logic [P*DW-1:0] b);
    int cyc = 0;
    in_y     = y;
    in_bias  = b;
    in_valid = 1'b1;
    push_expected(y, b);
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL load_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int max_beats, output int beats);
    exp_t          e;
    bit            stalled = 1'b0;
    bit            done = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] pd;
    logic [1:0]    pr;
    logic [2:0]    pc;
    logic          pl;
    beats = 0;
    while (!done && cyc < 400) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        n_cmp++;
        if ({out_valid, out_data, out_row, out_col, out_last} !== {1'b1, pd, pr, pc, pl}) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b d=%h r=%0d c=%0d l=%0b required v=1 d=%h r=%0d c=%0d l=%0b",
                   out_valid, out_data, out_row, out_col, out_last, pd, pr, pc, pl);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got d=%h with empty scoreboard required none", out_data);
          done = 1'b1;
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d) begin
            n_err++;
            $display("FAIL beat_data(%0d,%0d): got %h required %h", e.r, e.c, out_data, e.d);
          end
          n_cmp++;
          if (int'(out_row) != e.r || int'(out_col) != e.c) begin
            n_err++;
            $display("FAIL beat_index: got (%0d,%0d) required (%0d,%0d)", out_row, out_col, e.r, e.c);
          end
          n_cmp++;
          if (out_last !== e.last) begin
            n_err++;
            $display("FAIL beat_last(%0d,%0d): got %0b required %0b", e.r, e.c, out_last, e.last);
          end
          beats++;
          if (e.last || beats == max_beats) done = 1'b1;
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        pd = out_data;
        pr = out_row;
        pc = out_col;
        pl = out_last;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: beats=%0d required %0d", beats, max_beats);
    end
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b required 1/0", tag, in_ready, out_valid);
    end
  endtask

  task automatic fill(output logic [M*P*DW-1:0] y, input logic [DW-1:0] v);
    for (int i = 0; i < M*P; i++) y[i*DW +: DW] = v;
  endtask

  task automatic fill_bias(output logic [P*DW-1:0] b, input logic [DW-1:0] v);
    for (int i = 0; i < P; i++) b[i*DW +: DW] = v;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, in_ready, out_data, out_row, out_col, out_last} !== {1'b0, 1'b1, 16'h0, 2'd0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: v=%0b rdy=%0b d=%h r=%0d c=%0d l=%0b required 0 1 0000 0 0 0",
               out_valid, in_ready, out_data, out_row, out_col, out_last);
    end
  endtask

  task automatic test_basic();
    logic [M*P*DW-1:0] y;
    logic [P*DW-1:0]   b;
    int                beats;
    fill(y, 16'h0300);
    fill_bias(b, 16'h0000);
    load_matrix(y, b);
    drain(1'b0, M*P, beats);
    n_cmp++;
    if (beats != M*P) begin
      n_err++;
      $display("FAIL basic_beats: got %0d required %0d", beats, M*P);
    end
    check_idle("basic_return_idle");
  endtask

  task automatic test_negative_bias();
    logic [M*P*DW-1:0] y;
    logic [P*DW-1:0]   b;
    int                beats;
    fill(y, 16'hFE00);
    fill_bias(b, 16'h0100);
    load_matrix(y, b);
    drain(1'b0, M*P, beats);
    check_idle("neg_return_idle");
  endtask

  task automatic test_saturation();
    logic [M*P*DW-1:0] y;
    logic [P*DW-1:0]   b;
    int                beats;
    for (int i = 0; i < M*P; i++) y[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < P; i++) b[i*DW +: DW] = DW'($urandom);
    y[0*DW +: DW] = 16'h7F00;
    b[0*DW +: DW] = 16'h0200;
    y[1*DW +: DW] = 16'h8100;
    b[1*DW +: DW] = 16'hFE00;
    load_matrix(y, b);
    drain(1'b0, M*P, beats);
    check_idle("sat_return_idle");
  endtask

  task automatic test_backpressure();
    logic [M*P*DW-1:0] y1, y2;
    logic [P*DW-1:0]   b1, b2;
    int                beats;
    for (int i = 0; i < M*P; i++) y1[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < M*P; i++) y2[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < P; i++) b1[i*DW +: DW] = DW'($urandom_range(0, 16'h0FFF));
    for (int i = 0; i < P; i++) b2[i*DW +: DW] = DW'($urandom);
    load_matrix(y1, b1);
    in_y     = y2;
    in_bias  = b2;
    in_valid = 1'b1;
    push_expected(y2, b2);
    drain(1'b1, M*P, beats);
    n_cmp++;
    if (beats != M*P) begin
      n_err++;
      $display("FAIL bp_first_beats: got %0d required %0d", beats, M*P);
    end
    check_idle("bp_bubble");
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_start: out_valid=%0b required 1", out_valid);
    end
    drain(1'b1, M*P, beats);
    n_cmp++;
    if (beats != M*P) begin
      n_err++;
      $display("FAIL bp_second_beats: got %0d required %0d", beats, M*P);
    end
    check_idle("bp_return_idle");
  endtask

  task automatic test_mid_reset();
    logic [M*P*DW-1:0] y;
    logic [P*DW-1:0]   b;
    int                beats;
    for (int i = 0; i < M*P; i++) y[i*DW +: DW] = DW'($urandom);
    fill_bias(b, 16'h0040);
    load_matrix(y, b);
    drain(1'b0, 7, beats);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_valid: out_valid=%0b required 0", out_valid);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset_idle");
    for (int i = 0; i < M*P; i++) y[i*DW +: DW] = DW'($urandom);
    fill_bias(b, 16'hFF80);
    load_matrix(y, b);
    drain(1'b0, M*P, beats);
    n_cmp++;
    if (beats != M*P) begin
      n_err++;
      $display("FAIL post_reset_beats: got %0d required %0d", beats, M*P);
    end
    check_idle("post_reset_return_idle");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_y      = '0;
    in_bias   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_negative_bias();
    test_saturation();
    test_backpressure();
    test_mid_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_bias_relu_streamer.md
# matmul_bias_relu_streamer

Downstream companion to `matrix_multiplier`. It captures one complete flat M×P signed fixed-point result bus (`y`) with a per-column bias vector, adds the bias with saturation, and optionally applies ReLU. It then serialises the M×P elements row-major over a valid/ready stream toward the next CRNN stage. It decouples the combinational multiplier from downstream backpressure.

## Interface
- `M`, 4: result rows.
- `P`, 5: result columns.
- `DATA_WIDTH`, 16: element width, two's complement, sign included.
- `FRACT_WIDTH`, 8: fractional bits; informational only, since bias and y share the format.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_y` and `in_bias` are valid.
- `in_ready` output 1: block can accept a matrix.
- `in_y` input M\*P\*DATA_WIDTH: element (r,c) at bits [(r\*P+c)\*DATA_WIDTH +: DATA_WIDTH].
- `in_bias` input P\*DATA_WIDTH: bias for column c at [c\*DATA_WIDTH +: DATA_WIDTH].
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_WIDTH: processed element.
- `out_row` output max(1,$clog2(M)): row index of the current element.
- `out_col` output max(1,$clog2(P)): column index of the current element.
- `out_last` output 1: high with element (M-1,P-1).

## Operation
- FSM states IDLE and STREAM. Reset state is IDLE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`: register `in_y` and `in_bias`, clear row/col counters, go to STREAM.
- STREAM:
  - `in_ready`=0; `in_valid` is ignored.
  - `out_valid`=1.
  - `out_data` is derived from the captured registers and the counters.
- Arithmetic per element:
  - sum = sext(y[r][c]) + sext(bias[c]) in DATA_WIDTH+1 bits.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Then ReLU if enabled (see Configuration).
  - No rounding or shift is applied, because the formats match.
- Advance on `out_valid`&&`out_ready`:
  - col+1.
  - At col=P−1: col←0, row+1.
  - On the handshake of (M−1,P−1): go to IDLE.
- Stalled outputs: `out_data`, `out_row`, `out_col` and `out_last` hold stable while `out_valid`&&!`out_ready`.
- Captured registers are not modified during STREAM.

## Timing
- Reset values:
  - state=IDLE, counters=0, captured y/bias=0.
  - `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `in_ready`=1.
- Reset is asynchronous: asserting `rst` mid-STREAM drops `out_valid` immediately. The partially sent matrix is discarded.
- Latency: input handshake at edge k → first element valid in the cycle after edge k.
- Throughput: one element per cycle with `out_ready` held high. A full matrix takes M\*P cycles.
- Back-to-back: after the last-element handshake there is one IDLE cycle with `in_ready`=1. A held `in_valid` is accepted there, so there is exactly one bubble between matrices.
- `in_ready` is a pure function of state and never depends combinationally on `in_valid`.
- M=1 or P=1: the counters still work; the index outputs are 1 bit wide and stay 0.

## Configuration
- `MATMUL_RELU_EN` defined: after saturation, any negative result is forced to 0.
- `MATMUL_RELU_EN` undefined: the saturated signed sum passes through unchanged.

## Structure
- Shared package `crnn_fixed_pkg`:
  - Q-format constants DATA_WIDTH=16, FRACT_WIDTH=8.
  - Saturation limits SAT_MAX/SAT_MIN.
  - Stream state enum (IDLE, STREAM).
- One sub-module, `fixed_add_sat`:
  - Parameterised DATA_WIDTH, combinational sign-extended add plus saturate.
  - Reusable by other accumulate stages.

## Test plan
(M=4, P=5, DATA_WIDTH=16, FRACT_WIDTH=8)
- All y=0x0300 (3.0), bias=0, `out_ready`=1 → 20 beats of 0x0300 in order (0,0)…(3,4). `out_last` only on beat 20. `in_ready` returns to 1 the next cycle.
- All y=0xFE00 (−2.0), bias=0x0100 (1.0):
  - Without `MATMUL_RELU_EN` → every beat 0xFF00.
  - With it → every beat 0x0000.
- Saturation:
  - y(0,0)=0x7F00 with bias[0]=0x0200 → 0x7FFF.
  - y(0,1)=0x8100 with bias[1]=0xFE00 → 0x8000 without ReLU, 0x0000 with it.
- Backpressure:
  - Toggle `out_ready` every cycle, and hold `in_valid` with different data during STREAM.
  - Expect exactly 20 transfers, data stable across stalls, the second matrix not captured until after the last beat, and one bubble before the second matrix's first beat.
- Reset after 7 transfers:
  - `out_valid`=0 within the same cycle.
  - After release, `in_ready`=1.
  - A new matrix streams from (0,0) with no residue of the old one.
